// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the E stage. It owns architectural HI/LO, computes the result at issue
// and commits it after a fixed busy latency. Define MD_ABORT_EN to add the abort (exception flush) port.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
`ifdef MD_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q, hi_tmp_q, lo_tmp_q;
  logic [31:0] hi_res_d, lo_res_d;
  logic        abort_w;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_rs, abs_rt, div_rt, quo_u, rem_u;
  logic        neg_rs, neg_rt;

`ifdef MD_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Signed divide works on magnitudes, then restores signs: quotient truncates toward zero and
  // the remainder follows the dividend. A zero divisor is replaced so the divider never sees it.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    hi_res_d = '0;
    lo_res_d = '0;
    prod_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u   = {32'b0, rs_val} * {32'b0, rt_val};
    neg_rs   = (op == OP_DIV) & rs_val[31];
    neg_rt   = (op == OP_DIV) & rt_val[31];
    abs_rs   = neg_rs ? -rs_val : rs_val;
    abs_rt   = neg_rt ? -rt_val : rt_val;
    div_rt   = (rt_val == '0) ? 32'd1 : abs_rt;
    quo_u    = abs_rs / div_rt;
    rem_u    = abs_rs % div_rt;
    case (op)
      OP_MULT:  {hi_res_d, lo_res_d} = prod_s;
      OP_MULTU: {hi_res_d, lo_res_d} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (rt_val == '0) begin
          hi_res_d = rs_val;
          lo_res_d = '1;
        end else begin
          lo_res_d = (neg_rs ^ neg_rt) ? -quo_u : quo_u;
          hi_res_d = neg_rs ? -rem_u : rem_u;
        end
      end
      default: ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort_w) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                hi_tmp_q <= hi_res_d;
                lo_tmp_q <= lo_res_d;
                cnt_q    <= MULT_CNT;
                state_q  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                hi_tmp_q <= hi_res_d;
                lo_tmp_q <= lo_res_d;
                cnt_q    <= DIV_CNT;
                state_q  <= RUN;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Abort wins over commit, so a flushed op never reaches HI/LO even in its last cycle.
          if (abort_w) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
          end else if (cnt_q == 4'd1) begin
            hi_q    <= hi_tmp_q;
            lo_q    <= lo_tmp_q;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign stall_req = start | busy;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; the abort scenarios run only when MD_ABORT_EN is defined.
module tb_muldiv_ctrl;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic [2:0]  op     = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
`ifdef MD_ABORT_EN
  logic        abort  = 1'b0;
`endif
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
`ifdef MD_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, scramble the operands, then expect exactly n busy cycles with HI/LO
  // frozen, followed by the committed result. A stray MULT start is injected at busy cycle 'intrude'.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el, input int intrude);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    check("stall_at_issue", 32'(stall_req), 32'd1);
    check("idle_before_issue", 32'(busy), 32'd0);
    tick();
    start = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0000_0003;
    for (int i = 0; i < n; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("stall_run", 32'(stall_req), 32'd1);
      check("hi_frozen", hi, m_hi);
      check("lo_frozen", lo, m_lo);
      if (i == intrude) begin
        start = 1'b1; op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
      end
      tick();
      start = 1'b0;
    end
    check("busy_done", 32'(busy), 32'd0);
    check("stall_done", 32'(stall_req), 32'd0);
    check("hi_commit", hi, eh);
    check("lo_commit", lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; rs_val = v;
    #1;
    check("mt_stall", 32'(stall_req), 32'd1);
    tick();
    start = 1'b0;
    if (o == 3'd4) m_hi = v;
    else if (o == 3'd5) m_lo = v;
    check("mt_busy", 32'(busy), 32'd0);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op(3'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, -1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, -1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd10, 10, 32'd5, 32'h1999_9999, -1);
    run_op(3'd2, 32'd100, 32'd7, 10, 32'd2, 32'd14, 3);

    move_to(3'd4, 32'h1234_5678);
    move_to(3'd5, 32'h0000_ABCD);
    move_to(3'd6, 32'h5555_5555);
    move_to(3'd7, 32'hAAAA_AAAA);

    // Asynchronous reset in busy cycle 3 of a DIV, away from any clock edge.
    start = 1'b1; op = 3'd2; rs_val = 32'd64; rt_val = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_idle", 32'(busy), 32'd0);
    end
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);

`ifdef MD_ABORT_EN
    move_to(3'd4, 32'd5);
    move_to(3'd5, 32'd6);
    start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_last_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd5);
    check("abort_lo", lo, 32'd6);
    for (int i = 0; i < 6; i++) tick();
    check("abort_hi_kept", hi, 32'd5);
    check("abort_lo_kept", lo, 32'd6);
    start = 1'b1; op = 3'd4; rs_val = 32'd99; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_mthi_hi", hi, 32'd5);
    check("abort_mthi_busy", 32'(busy), 32'd0);
    start = 1'b1; op = 3'd2; rs_val = 32'd9; rt_val = 32'd2; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_div_busy", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
